// File: rtl/seg_disp_arb.sv
// Six-digit display source arbiter: background digits with per-digit blink,
// preempted by a timed overlay that can be re-triggered or cancelled.
module seg_disp_arb #(
    parameter int unsigned HOLD_CYC   = 50_000_000,
    parameter int unsigned BLINK_CYC  = 12_500_000,
    parameter logic [3:0]  BLANK_CODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] bg_data,
    input  logic        ov_req,
    input  logic [23:0] ov_data,
    input  logic        ov_cancel,
    input  logic [5:0]  blink_mask,
    output logic        ov_ack,
    output logic        ov_busy,
    output logic        src,
    output logic [3:0]  dis1,
    output logic [3:0]  dis2,
    output logic [3:0]  dis3,
    output logic [3:0]  dis4,
    output logic [3:0]  dis5,
    output logic [3:0]  dis6
);
    localparam int HW = ($clog2(HOLD_CYC)  < 1) ? 1 : $clog2(HOLD_CYC);
    localparam int BW = ($clog2(BLINK_CYC) < 1) ? 1 : $clog2(BLINK_CYC);
    localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYC - 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_CYC - 1);

    typedef enum logic {S_BG, S_OV} state_t;

    state_t          r_state;
    logic [HW-1:0]   r_hold;
    logic [BW-1:0]   r_blink_cnt;
    logic            r_blink_ph;
    logic [23:0]     r_ov_data;
    logic [5:0][3:0] r_dis;
    logic            r_ack;
    logic            r_busy;
    logic [5:0][3:0] w_bg_dis;

    // Background digits after blink blanking
    for (genvar i = 0; i < 6; i++) begin : g_blank
        assign w_bg_dis[i] = (r_blink_ph && blink_mask[i]) ? BLANK_CODE : bg_data[4*i +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (r_blink_cnt == BLINK_TC) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_BG;
            r_hold    <= '0;
            r_ov_data <= '0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_dis     <= {6{BLANK_CODE}};
        end else if (ov_req) begin
            // Accept and re-trigger are the same action; the request beats cancel and expiry
            r_state   <= S_OV;
            r_hold    <= HOLD_LD;
            r_ov_data <= ov_data;
            r_ack     <= 1'b1;
            r_busy    <= 1'b1;
            r_dis     <= ov_data;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_OV: begin
                    if (ov_cancel || r_hold == '0) begin
                        r_state <= S_BG;
                        r_busy  <= 1'b0;
                        r_dis   <= w_bg_dis;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                        r_dis  <= r_ov_data;
                    end
                end
                default: begin
                    r_state <= S_BG;
                    r_busy  <= 1'b0;
                    r_dis   <= w_bg_dis;
                end
            endcase
        end
    end

    assign ov_ack  = r_ack;
    assign ov_busy = r_busy;
    assign src     = r_busy;
    assign dis1    = r_dis[0];
    assign dis2    = r_dis[1];
    assign dis3    = r_dis[2];
    assign dis4    = r_dis[3];
    assign dis5    = r_dis[4];
    assign dis6    = r_dis[5];
endmodule

// File: tb/tb_seg_disp_arb.sv
// Directed bench for seg_disp_arb with HOLD_CYC=10, BLINK_CYC=4.
module tb_seg_disp_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] bg_data;
    logic        ov_req;
    logic [23:0] ov_data;
    logic        ov_cancel;
    logic [5:0]  blink_mask;
    logic        ov_ack, ov_busy, src;
    logic [3:0]  dis1, dis2, dis3, dis4, dis5, dis6;

    int n_chk = 0;
    int n_err = 0;

    seg_disp_arb #(.HOLD_CYC(10), .BLINK_CYC(4), .BLANK_CODE(4'hF)) dut (
        .clk(clk), .rst(rst), .bg_data(bg_data), .ov_req(ov_req), .ov_data(ov_data),
        .ov_cancel(ov_cancel), .blink_mask(blink_mask), .ov_ack(ov_ack), .ov_busy(ov_busy),
        .src(src), .dis1(dis1), .dis2(dis2), .dis3(dis3), .dis4(dis4), .dis5(dis5), .dis6(dis6)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] dis_all();
        return {dis6, dis5, dis4, dis3, dis2, dis1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts overlay cycles from the current one (already counted in n) until BG returns
    task automatic run_ov(input logic [23:0] exp_dis, inout int n, output int acks);
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!src) return;
            n++;
            if (ov_ack) acks++;
            chk("ov_dis", dis_all(), exp_dis);
        end
        chk("ov_timeout", 1, 0);
    endtask

    task automatic accept(input logic [23:0] d);
        ov_req = 1'b1; ov_data = d;
        tick();
        ov_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int n, acks;
    logic [11:0] blink_pat;

    initial begin
        rst = 1'b1; bg_data = 24'h654321; ov_req = 0; ov_data = 0; ov_cancel = 0; blink_mask = 0;
        tick(); tick();
        chk("rst_dis", dis_all(), 24'hFFFFFF);
        chk("rst_src", src, 0);
        chk("rst_busy", ov_busy, 0);
        chk("rst_ack", ov_ack, 0);
        rst = 1'b0;
        tick();
        chk("bg_dis", dis_all(), 24'h654321);
        chk("bg_src", src, 0);
        chk("bg_ack", ov_ack, 0);
        bg_data = 24'h987654;
        tick();
        chk("bg_follow", dis_all(), 24'h987654);
        bg_data = 24'h654321;
        tick();

        // Plain overlay: exactly 10 cycles, one ack
        accept(24'hABCDEF);
        chk("acc_ack", ov_ack, 1);
        chk("acc_src", src, 1);
        chk("acc_busy", ov_busy, 1);
        chk("acc_dis", dis_all(), 24'hABCDEF);
        n = 1;
        run_ov(24'hABCDEF, n, acks);
        chk("ov_len", n, 10);
        chk("ov_extra_ack", acks, 0);
        chk("ov_end_dis", dis_all(), 24'h654321);
        chk("ov_end_busy", ov_busy, 0);

        // Re-trigger at cycle 5: 15 cycles total
        accept(24'hABCDEF);
        repeat (4) tick();
        accept(24'h111111);
        chk("rt_ack", ov_ack, 1);
        chk("rt_dis", dis_all(), 24'h111111);
        n = 6;
        run_ov(24'h111111, n, acks);
        chk("rt_len", n, 15);

        // Cancel at cycle 3
        accept(24'hABCDEF);
        tick(); tick();
        ov_cancel = 1'b1;
        tick();
        ov_cancel = 1'b0;
        chk("cxl_src", src, 0);
        chk("cxl_busy", ov_busy, 0);
        chk("cxl_dis", dis_all(), 24'h654321);

        // Cancel in BG ignored
        ov_cancel = 1'b1;
        tick();
        ov_cancel = 1'b0;
        chk("bgcxl_src", src, 0);
        chk("bgcxl_ack", ov_ack, 0);

        // Request + cancel together: request wins, both from BG and in OV
        ov_cancel = 1'b1;
        accept(24'h222222);
        chk("rc_bg_ack", ov_ack, 1);
        chk("rc_bg_src", src, 1);
        accept(24'h333333);
        ov_cancel = 1'b0;
        chk("rc_ov_ack", ov_ack, 1);
        chk("rc_ov_dis", dis_all(), 24'h333333);
        ov_cancel = 1'b1;
        tick();
        ov_cancel = 1'b0;
        chk("rc_exit", src, 0);

        // Expiry coinciding with request: stays OV
        accept(24'h444444);
        repeat (9) tick();
        chk("exp_last", src, 1);
        accept(24'h555555);
        chk("exp_req_src", src, 1);
        chk("exp_req_ack", ov_ack, 1);
        chk("exp_req_dis", dis_all(), 24'h555555);
        ov_cancel = 1'b1;
        tick();
        ov_cancel = 1'b0;

        // Reset mid-overlay, then first request accepted
        accept(24'hABCDEF);
        tick();
        rst = 1'b1;
        tick();
        chk("rov_dis", dis_all(), 24'hFFFFFF);
        chk("rov_src", src, 0);
        chk("rov_busy", ov_busy, 0);
        chk("rov_ack", ov_ack, 0);
        rst = 1'b0;
        accept(24'hABCDEF);
        chk("post_rst_ack", ov_ack, 1);
        chk("post_rst_dis", dis_all(), 24'hABCDEF);
        ov_cancel = 1'b1;
        tick();
        ov_cancel = 1'b0;

        // Blink on digit1: phase is 0 for the first 4 post-reset edges, then 1 for 4, ...
        blink_mask = 6'b000001;
        do_reset();
        blink_pat = 12'b0000_1111_0000;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("blink", dis_all(), blink_pat[11-i] ? 24'h65432F : 24'h654321);
        end
        // Overlay spans a phase toggle but is never blanked
        accept(24'h123456);
        chk("blink_ov_acc", dis_all(), 24'h123456);
        n = 1;
        run_ov(24'h123456, n, acks);
        chk("blink_ov_len", n, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
